dsp_delay_line: RTL and testbench
=================================

# dsp_delay_line

Parametrised, runtime-selectable pipeline delay line for the DSP datapath. It generalises the single optional register stage into a chain of up to MAX_DEPTH registers. The active latency (0..MAX_DEPTH) is chosen at run time, and a valid tag travels with the data. Depth changes are handled safely: the chain drains before the new depth takes effect, so no sample is duplicated or lost.

## Interface
- WIDTH, 18, data width in bits.
- MAX_DEPTH, 4, number of physical register stages (≥1).
- RST_DEPTH, 1, active depth after reset (0..MAX_DEPTH).
- DW, $clog2(MAX_DEPTH+1), width of depth and occupancy fields (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ce  in  1  clock enable; 0 freezes all stage data and valid bits.
- flush  in  1  synchronous clear of all valid bits. Data is kept. Acts regardless of ce.
- depth_sel  in  DW  requested latency in ce-cycles.
- in_data  in  WIDTH  input sample.
- in_valid  in  1  input sample qualifier.
- in_ready  out  1  block accepts input this cycle.
- out_data  out  WIDTH  delayed sample.
- out_valid  out  1  out_data qualifier.
- depth_err  out  1  sticky flag: depth_sel > MAX_DEPTH was seen.
- occ  out  DW  count of valid bits in active stages (see Configuration).

## Operation
- Clamping: depth_c = min(depth_sel, MAX_DEPTH).
  - If depth_sel > MAX_DEPTH on any clock edge, depth_err is set.
  - depth_err clears only on rst.
- Active depth register depth_q:
  - Reset value is RST_DEPTH.
  - Changes only through the FSM below.
- Stage 0 on an edge with ce=1:
  - data0 <= in_data.
  - v0 <= in_valid & in_ready.
- Stage k>0 on an edge with ce=1:
  - data_k <= data_{k-1}.
  - v_k <= v_{k-1}.
- All stages shift together. Stages at index ≥ depth_q also shift but are ignored.
- Output selection:
  - depth_q = 0: out_data = in_data, out_valid = in_valid & in_ready. This path is combinational.
  - depth_q = d > 0: out_data = data_{d-1}, out_valid = v_{d-1}.
- Empty: pipe empty means all v_k for k < depth_q are 0. With depth_q = 0 the pipe is always empty.
- FSM states: RUN, DRAIN.
  - RUN → DRAIN on an edge where depth_c ≠ depth_q.
  - DRAIN → RUN on an edge where the pipe is empty or flush=1. On that edge depth_q <= depth_c, sampled at that edge.
  - If depth_c equals depth_q again during DRAIN, the FSM still completes the drain.
- in_ready = (state==RUN) && (depth_c == depth_q). This is combinational on depth_sel, so the sample on the cycle of a depth mismatch is not accepted.
- flush clears every v_k at the edge, with priority over ce. In the same edge, stage 0 does not capture a new valid.
- Reset mid-operation:
  - All data_k and v_k go to 0.
  - State goes to RUN, depth_q to RST_DEPTH, depth_err to 0.
  - Effect is immediate (asynchronous).

## Timing
- A sample accepted at edge N with depth d>0 appears at out_data/out_valid after d edges with ce=1.
- With ce=1 continuously, output is valid in the cycle following edge N+d-1.
- ce=0 cycles add latency one for one.
- Throughput is 1 sample/cycle in RUN with ce=1.
- A drain lasts at most depth_q ce-cycles. flush completes it in 1 cycle.
- in_ready low lasts from the mismatch cycle through the DRAIN→RUN edge, inclusive of the cycle before that edge.
- Reset values:
  - out_data = 0 if RST_DEPTH>0, otherwise in_data.
  - out_valid = 0 (if RST_DEPTH=0, in_valid is ignored while rst is asserted).
  - in_ready = 1 if depth_c == RST_DEPTH.
  - depth_err = 0.
  - occ = 0.

## Configuration
- Macro DSP_DELAY_LINE_OCC_EN.
- Defined:
  - occ is a registered popcount of v_k for k < depth_q.
  - It updates on the same edge as the valid bits and reads 0 after flush or reset.
- Undefined:
  - occ is tied to 0 and no counter logic is built.
  - The port list is unchanged.

## Test plan
- Reset, RST_DEPTH=1, MAX_DEPTH=4, ce=1, in_valid=1, then in_data 0x00001..0x00005 on consecutive cycles -> out_data shows 0x00001..0x00005 one cycle later each, out_valid=1.
- depth_sel=3 at steady state after streaming 0x10,0x11,0x12 at depth 1 -> in_ready=0 the same cycle. 0x12 exits, DRAIN→RUN, depth_q=3. The next accepted 0x20 emerges exactly 3 cycles after acceptance.
- depth 2, accept 0xAA, ce held 0 for 5 cycles, then ce=1 -> 0xAA appears after 2 ce=1 edges. Outputs are stable throughout the stall.
- depth 4 with 3 valid in flight, flush=1 with ce=0 -> all out_valid=0 next cycle; occ=0 when DSP_DELAY_LINE_OCC_EN is defined.
- depth_sel=7 with MAX_DEPTH=4 -> depth_err=1 and stays 1 after depth_sel=2. Effective depth becomes 4 after the drain.
- depth_sel=0 -> out_data follows in_data combinationally and out_valid = in_valid. Asserting rst mid-stream at depth 3 -> out_valid=0 immediately; depth_q returns to RST_DEPTH.

Source files
------------

// File: rtl/dsp_delay_line.sv
// dsp_delay_line: runtime-selectable 0..MAX_DEPTH register delay line with valid tag and drain-before-retime
// Optional feature macro: DSP_DELAY_LINE_OCC_EN (registered occupancy count on occ; occ tied to 0 otherwise).
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   ce            clock enable for stage data and valid bits
//   flush         synchronous clear of all valid bits (data kept), independent of ce
//   depth_sel     requested latency, clamped to MAX_DEPTH
//   in_data/in_valid/in_ready   input sample, qualifier, acceptance
//   out_data/out_valid          delayed sample and qualifier
//   depth_err     sticky: depth_sel > MAX_DEPTH was seen
//   occ           valid count in active stages (0 unless DSP_DELAY_LINE_OCC_EN)
module dsp_delay_line #(
    parameter int WIDTH = 18,
    parameter int MAX_DEPTH = 4,
    parameter int RST_DEPTH = 1,
    localparam int DW = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [DW-1:0]    depth_sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             depth_err,
    output logic [DW-1:0]    occ
);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] RST_D = DW'(RST_DEPTH);
    typedef enum logic {RUN, DRAIN} state_t;
    state_t state, state_n;
    logic [DW-1:0] depth_q, depth_c, depth_n;
    logic [WIDTH-1:0] data [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] v, v_n, act;
    logic empty, swap;
    assign depth_c = (depth_sel > MAX_D) ? MAX_D : depth_sel;
    assign in_ready = (state == RUN) && (depth_c == depth_q);
    assign empty = (v & act) == '0;
    // the new depth is adopted only once the active stages hold nothing valid
    assign swap = (state == DRAIN) && (empty || flush);
    assign depth_n = swap ? depth_c : depth_q;
    always_comb begin
        act = '0;
        for (int k = 0; k < MAX_DEPTH; k++) act[k] = DW'(k) < depth_q;
    end
    always_comb begin
        v_n = v;
        if (flush) v_n = '0;
        else if (ce) begin
            v_n[0] = in_valid & in_ready;
            for (int k = 1; k < MAX_DEPTH; k++) v_n[k] = v[k-1];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_DEPTH; k++) data[k] <= '0;
        end else if (ce) begin
            data[0] <= in_data;
            for (int k = 1; k < MAX_DEPTH; k++) data[k] <= data[k-1];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            depth_q   <= RST_D;
            v         <= '0;
            depth_err <= 1'b0;
        end else begin
            state     <= state_n;
            depth_q   <= depth_n;
            v         <= v_n;
            depth_err <= depth_err | (depth_sel > MAX_D);
        end
    end
    always_comb state_n = (state == RUN) ? ((depth_c != depth_q) ? DRAIN : RUN) : (swap ? RUN : DRAIN);
    // depth 0 is a combinational bypass; rst masks it so nothing is seen as valid during reset
    always_comb begin
        out_data  = in_data;
        out_valid = in_valid & in_ready & ~rst;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (depth_q == DW'(k + 1)) begin
                out_data  = data[k];
                out_valid = v[k];
            end
        end
    end
`ifdef DSP_DELAY_LINE_OCC_EN
    logic [DW-1:0] occ_q, occ_n;
    // counts the post-edge valid bits against the post-edge depth so occ tracks v on the same edge
    always_comb begin
        occ_n = '0;
        for (int k = 0; k < MAX_DEPTH; k++) occ_n = occ_n + DW'(v_n[k] && (DW'(k) < depth_n));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) occ_q <= '0;
        else occ_q <= occ_n;
    end
    assign occ = occ_q;
`else
    assign occ = '0;
`endif
endmodule

// File: tb/tb_dsp_delay_line.sv
// tb_dsp_delay_line: directed self-checking bench for dsp_delay_line (WIDTH=18, MAX_DEPTH=4, RST_DEPTH=1)
module tb_dsp_delay_line;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b1;
    logic flush = 1'b0;
    logic [2:0] depth_sel = 3'd1;
    logic [17:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready, out_valid, depth_err;
    logic [17:0] out_data;
    logic [2:0] occ;
    int total = 0;
    int bad = 0;
`ifdef DSP_DELAY_LINE_OCC_EN
    localparam logic [2:0] OCC3 = 3'd3;
`else
    localparam logic [2:0] OCC3 = 3'd0;
`endif

    dsp_delay_line #(.WIDTH(18), .MAX_DEPTH(4), .RST_DEPTH(1)) dut (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .depth_sel(depth_sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .depth_err(depth_err), .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; in_valid = 1'b1; depth_sel = 3'd1; in_data = 18'h155;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 18'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (depth_err !== 1'b0) begin bad++; $display("FAIL reset_depth_err got=%b want=0", depth_err); end
        total++; if (occ !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occ); end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_stream_depth1();
        for (int i = 1; i <= 5; i++) begin
            in_data = 18'(i); in_valid = 1'b1;
            tick();
            total++; if (out_data !== 18'(i) || out_valid !== 1'b1) begin bad++; $display("FAIL stream_d1[%0d] got=%h/%b want=%h/1", i, out_data, out_valid, 18'(i)); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_d1_idle got=%b want=0", out_valid); end
    endtask

    task automatic test_depth_change();
        for (int i = 0; i < 3; i++) begin
            in_data = 18'(16 + i); in_valid = 1'b1;
            tick();
            total++; if (out_data !== 18'(16 + i) || out_valid !== 1'b1) begin bad++; $display("FAIL chg_pre[%0d] got=%h/%b want=%h/1", i, out_data, out_valid, 18'(16 + i)); end
        end
        depth_sel = 3'd3; in_data = 18'h99;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL chg_ready_mismatch got=%b want=0", in_ready); end
        tick();
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL chg_drain got=ready %b valid %b want=0/0", in_ready, out_valid); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL chg_run_d3 got=%b want=1", in_ready); end
        in_data = 18'h20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL chg_lat_e0 got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL chg_lat_e1 got=%b want=0", out_valid); end
        tick();
        total++; if (out_data !== 18'h20 || out_valid !== 1'b1) begin bad++; $display("FAIL chg_lat_e2 got=%h/%b want=20/1", out_data, out_valid); end
    endtask

    task automatic test_stall();
        in_valid = 1'b0; in_data = '0;
        repeat (4) tick();
        depth_sel = 3'd2;
        repeat (2) tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_run_d2 got=%b want=1", in_ready); end
        in_data = 18'hAA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 18'h3FFFF; ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (out_valid !== 1'b0 || out_data !== 18'h0) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%b want=0/0", i, out_data, out_valid); end
        end
        ce = 1'b1;
        tick();
        total++; if (out_data !== 18'hAA || out_valid !== 1'b1) begin bad++; $display("FAIL stall_release got=%h/%b want=aa/1", out_data, out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_after got=%b want=0", out_valid); end
    endtask

    task automatic test_depth_err();
        depth_sel = 3'd7; in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL err_ready_mismatch got=%b want=0", in_ready); end
        tick();
        total++; if (depth_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", depth_err); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL err_clamped_run got=%b want=1", in_ready); end
        in_data = 18'h55; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL err_lat_e%0d got=%b want=0", i, out_valid); end
            tick();
        end
        total++; if (out_data !== 18'h55 || out_valid !== 1'b1) begin bad++; $display("FAIL err_lat_e3 got=%h/%b want=55/1", out_data, out_valid); end
        depth_sel = 3'd4;
        tick();
        total++; if (depth_err !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL err_sticky got=err %b ready %b want=1/1", depth_err, in_ready); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) begin
            in_data = 18'(i); in_valid = 1'b1;
            tick();
        end
        total++; if (out_valid !== 1'b0 || occ !== OCC3) begin bad++; $display("FAIL flush_pre got=valid %b occ %0d want=0/%0d", out_valid, occ, OCC3); end
        flush = 1'b1; ce = 1'b0;
        tick();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || occ !== 3'd0) begin bad++; $display("FAIL flush_now got=valid %b occ %0d want=0/0", out_valid, occ); end
        ce = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drained[%0d] got=%b want=0", i, out_valid); end
        end
    endtask

    task automatic test_depth0();
        depth_sel = 3'd0; in_valid = 1'b0;
        repeat (2) tick();
        in_data = 18'h123; in_valid = 1'b1;
        #1;
        total++; if (out_data !== 18'h123 || out_valid !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL d0_pass got=%h/%b/%b want=123/1/1", out_data, out_valid, in_ready); end
        in_data = 18'h3FFFF; in_valid = 1'b0;
        #1;
        total++; if (out_data !== 18'h3FFFF || out_valid !== 1'b0) begin bad++; $display("FAIL d0_idle got=%h/%b want=3ffff/0", out_data, out_valid); end
        total++; if (depth_err !== 1'b1) begin bad++; $display("FAIL d0_err_sticky got=%b want=1", depth_err); end
    endtask

    task automatic test_rst_mid();
        depth_sel = 3'd3; in_valid = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            in_data = 18'(8'h31 + i); in_valid = 1'b1;
            tick();
        end
        total++; if (out_data !== 18'h31 || out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%h/%b want=31/1", out_data, out_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 18'h0) begin bad++; $display("FAIL rstmid_out got=%h/%b want=0/0", out_data, out_valid); end
        total++; if (in_ready !== 1'b0 || depth_err !== 1'b0 || occ !== 3'd0) begin bad++; $display("FAIL rstmid_state got=ready %b err %b occ %0d want=0/0/0", in_ready, depth_err, occ); end
        depth_sel = 3'd1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_depth1 got=%b want=1", in_ready); end
        tick();
        rst = 1'b0; in_data = 18'h44; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_data !== 18'h44 || out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_resume got=%h/%b want=44/1", out_data, out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream_depth1();
        test_depth_change();
        test_stall();
        test_depth_err();
        test_flush();
        test_depth0();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
